// File: rtl/ifu_pfq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ifu_pfq
// Brief    : Instruction prefetch queue. Keeps up to OUTSTD word fetches in
//            flight, buffers words in a DEPTH-entry FIFO and realigns 16/32-bit
//            instructions. Optional counters: define IFU_PFQ_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_pfq #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4,
    parameter int OUTSTD = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              c_ext,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              pop,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    output logic              out_len4,
    output logic [1:0]        out_bad,
    output logic [ADDR_W-1:0] out_badaddr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_busy,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic [1:0]        imem_bad
`ifdef IFU_PFQ_PERF_EN
    ,
    output logic [31:0]       perf_starve,
    output logic [31:0]       perf_flush
`endif
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int IFL_W    = $clog2(OUTSTD + 1);
    localparam int DROP_W   = $clog2(OUTSTD * DEPTH + 1);
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic [31:0]       r_data [DEPTH];
    logic [1:0]        r_bad  [DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;
    logic [IFL_W-1:0]  r_inflight;
    logic [DROP_W-1:0] r_drop;
    logic [ADDR_W-1:0] r_fetch;
    logic [ADDR_W-1:0] r_pc;
    logic              r_off;

    logic [PTR_W-1:0]  w_nxt;
    logic [31:0]       w_head;
    logic [31:0]       w_next;
    logic [15:0]       w_parcel;
    logic              w_is16;
    logic              w_need2;
    logic              w_head_bad;
    logic              w_next_bad;
    logic              w_valid;
    logic [ADDR_W-1:0] w_next_addr;
    logic [31:0]       w_occ;
    logic              w_accept;
    logic              w_live_rsp;
    logic              w_any_rsp;
    logic              w_push;
    logic              w_adv;
    logic [1:0]        w_pos;
    logic              w_free;
    logic [31:0]       w_drop_sum;
    logic [DROP_W-1:0] w_drop_jump;

    // Head decode: the parcel offset picks the halfword the instruction starts in
    assign w_nxt       = r_rd + PTR_W'(1);
    assign w_head      = r_data[r_rd];
    assign w_next      = r_data[w_nxt];
    assign w_parcel    = r_off ? w_head[31:16] : w_head[15:0];
    assign w_is16      = c_ext && (w_parcel[1:0] != 2'b11);
    assign w_need2     = !w_is16 && r_off;
    assign w_head_bad  = (r_count != '0) && (r_bad[r_rd] != 2'b00);
    assign w_next_bad  = w_need2 && (r_count >= CNT_W'(2)) && (r_bad[w_nxt] != 2'b00);
    assign w_valid     = (r_count != '0) &&
                         (w_head_bad || !w_need2 || (r_count >= CNT_W'(2)));
    assign w_next_addr = {r_pc[ADDR_W-1:2], 2'b00} + ADDR_W'(4);

    assign out_valid = w_valid;
    assign out_pc    = r_pc;

    always_comb begin
        out_inst    = 32'h0;
        out_len4    = 1'b0;
        out_bad     = 2'b00;
        out_badaddr = '0;
        if (w_valid) begin
            out_len4 = !w_is16;
            if (w_is16)
                out_inst = {16'h0, w_parcel};
            else if (r_off)
                out_inst = {w_next[15:0], w_head[31:16]};
            else
                out_inst = w_head;
            if (w_head_bad) begin
                out_bad     = r_bad[r_rd];
                out_badaddr = r_pc;
            end else if (w_next_bad) begin
                out_bad     = r_bad[w_nxt];
                out_badaddr = w_next_addr;
            end
        end
    end

    // Requests are capped so every live response is guaranteed a FIFO slot
    assign w_occ     = 32'(r_count) + 32'(r_inflight);
    assign imem_req  = rstn && !jump && (r_inflight < IFL_W'(OUTSTD)) && (w_occ < 32'(DEPTH));
    assign imem_addr = r_fetch;
    assign w_accept  = imem_req && !imem_busy;

    assign w_live_rsp = imem_rvalid && (r_drop == '0) && (r_inflight != '0);
    assign w_any_rsp  = imem_rvalid && ((r_drop != '0) || (r_inflight != '0));
    assign w_push     = w_live_rsp && !jump;

    // A faulting instruction is never consumed, which keeps the fault on display
    assign w_adv  = pop && w_valid && !w_head_bad && !w_next_bad && !jump;
    assign w_pos  = {1'b0, r_off} + (w_is16 ? 2'd1 : 2'd2);
    assign w_free = w_adv && w_pos[1];

    // Live requests at a redirect become stale and join the drop count
    assign w_drop_sum  = 32'(r_drop) + 32'(r_inflight) - 32'(w_any_rsp);
    assign w_drop_jump = (w_drop_sum > 32'(DROP_MAX)) ? DROP_W'(DROP_MAX) : DROP_W'(w_drop_sum);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_fetch    <= '0;
            r_pc       <= '0;
            r_off      <= 1'b0;
        end else if (jump) begin
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= w_drop_jump;
            r_fetch    <= jump_addr & ~ADDR_W'(3);
            r_pc       <= jump_addr & ~ADDR_W'(1);
            r_off      <= jump_addr[1];
        end else begin
            if (w_accept)
                r_fetch <= r_fetch + ADDR_W'(4);
            if (w_push)
                r_wr <= r_wr + PTR_W'(1);
            if (w_free)
                r_rd <= r_rd + PTR_W'(1);
            r_count    <= r_count + CNT_W'(w_push) - CNT_W'(w_free);
            r_inflight <= r_inflight + IFL_W'(w_accept) - IFL_W'(w_live_rsp);
            if (imem_rvalid && (r_drop != '0))
                r_drop <= r_drop - DROP_W'(1);
            if (w_adv) begin
                r_pc  <= r_pc + (w_is16 ? ADDR_W'(2) : ADDR_W'(4));
                r_off <= w_pos[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr] <= imem_rdata;
            r_bad[r_wr]  <= imem_bad;
        end
    end

`ifdef IFU_PFQ_PERF_EN
    logic [31:0] r_perf_starve;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_starve <= 32'h0;
            r_perf_flush  <= 32'h0;
        end else begin
            if (!w_valid && !jump && (r_perf_starve != 32'hFFFF_FFFF))
                r_perf_starve <= r_perf_starve + 32'd1;
            if (imem_rvalid && ((r_drop != '0) || (jump && r_inflight != '0)) &&
                (r_perf_flush != 32'hFFFF_FFFF))
                r_perf_flush <= r_perf_flush + 32'd1;
        end
    end

    assign perf_starve = r_perf_starve;
    assign perf_flush  = r_perf_flush;
`endif

endmodule
`default_nettype wire
